// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_lock_sequencer                                           |
// | Description : Power-up / recovery sequencer for an iCE40 SB_PLL40_CORE.    |
// |               Runs on the 12 MHz reference clock, drives RESETB/BYPASS,    |
// |               qualifies the asynchronous LOCK output and publishes a       |
// |               single clk_ready flag. Re-sequences the PLL on loss of lock, |
// |               lock timeout or a restart request, and keeps a saturating    |
// |               count of failed attempts.                                    |
// | Optional    : `define PLL_SEQ_BYPASS_FALLBACK_EN adds a terminal FAIL      |
// |               state that runs the fabric from refclk through the bypass    |
// |               after MAX_RETRIES failed attempts.                           |
// | Ports       : refclk      in  reference clock (sole clock)                 |
// |               rst_n       in  asynchronous active-low reset                |
// |               pll_lock    in  PLL LOCK, asynchronous to refclk             |
// |               restart     in  single-cycle request to re-sequence          |
// |               pll_resetb  out PLL RESETB (low holds PLL in reset)          |
// |               pll_bypass  out PLL BYPASS                                   |
// |               clk_ready   out PLL output qualified and usable              |
// |               pll_failed  out fallback taken                               |
// |               retry_count out failed attempts, saturates at 15             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pll_lock_sequencer #(
  parameter int RESET_CYCLES       = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic       clk_ready,
  output logic       pll_failed,
  output logic [3:0] retry_count
);

  // The stable counter only ever holds values up to LOCK_STABLE_CYCLES-1: the
  // cycle that would take it to LOCK_STABLE_CYCLES is the cycle that enters RUN.
  localparam int STABLE_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

  localparam logic [15:0]         RESET_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0]         TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST  = STABLE_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAIL      = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                lock_meta_q, lock_meta_d;
  logic                lock_s_q, lock_s_d;
  // Shared phase counter: RESET hold length in RESET, lock timeout in WAIT_LOCK.
  logic [15:0]         phase_q, phase_d;
  logic [STABLE_W-1:0] stable_q, stable_d;
  logic [3:0]          retry_count_q, retry_count_d;
  logic                pll_resetb_q, pll_resetb_d;
  logic                clk_ready_q, clk_ready_d;
  logic                attempt_failed;
  logic [3:0]          retry_inc;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
  logic                pll_bypass_q, pll_bypass_d;
  logic                pll_failed_q, pll_failed_d;
`endif

  always_comb begin
    lock_meta_d    = pll_lock;
    lock_s_d       = lock_meta_q;
    state_d        = state_q;
    phase_d        = phase_q;
    stable_d       = stable_q;
    retry_count_d  = retry_count_q;
    attempt_failed = 1'b0;
    retry_inc      = (retry_count_q == 4'hF) ? 4'hF : retry_count_q + 4'd1;

    case (state_q)
      ST_RESET: begin
        if (phase_q == RESET_LAST) begin
          state_d = ST_WAIT_LOCK;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      ST_WAIT_LOCK: begin
        phase_d  = phase_q + 16'd1;
        stable_d = lock_s_q ? stable_q + 1'b1 : '0;
        // Lock is tested first so it wins a tie with the timeout.
        if (lock_s_q && (stable_q == STABLE_LAST)) begin
          state_d  = ST_RUN;
          phase_d  = '0;
          stable_d = '0;
        end else if (phase_q == TIMEOUT_LAST) begin
          attempt_failed = 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          attempt_failed = 1'b1;
        end
      end
      ST_FAIL: begin
        // Terminal; only restart or rst_n leave it.
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    if (attempt_failed) begin
      retry_count_d = retry_inc;
      state_d       = ST_RESET;
      phase_d       = '0;
      stable_d      = '0;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
      if (int'(retry_inc) == MAX_RETRIES) begin
        state_d = ST_FAIL;
      end
`endif
    end

    // Restart overrides any simultaneous failure, so the count clears rather
    // than increments.
    if (restart) begin
      state_d       = ST_RESET;
      phase_d       = '0;
      stable_d      = '0;
      retry_count_d = '0;
    end

    // Outputs are registered images of the next state.
    pll_resetb_d = (state_d != ST_RESET);
    clk_ready_d  = (state_d == ST_RUN) || (state_d == ST_FAIL);
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    pll_bypass_d = (state_d == ST_FAIL);
    pll_failed_d = (state_d == ST_FAIL);
`endif
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RESET;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      phase_q       <= '0;
      stable_q      <= '0;
      retry_count_q <= '0;
      pll_resetb_q  <= 1'b0;
      clk_ready_q   <= 1'b0;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
      pll_bypass_q  <= 1'b0;
      pll_failed_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      lock_meta_q   <= lock_meta_d;
      lock_s_q      <= lock_s_d;
      phase_q       <= phase_d;
      stable_q      <= stable_d;
      retry_count_q <= retry_count_d;
      pll_resetb_q  <= pll_resetb_d;
      clk_ready_q   <= clk_ready_d;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
      pll_bypass_q  <= pll_bypass_d;
      pll_failed_q  <= pll_failed_d;
`endif
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign clk_ready   = clk_ready_q;
  assign retry_count = retry_count_q;

`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
  assign pll_bypass = pll_bypass_q;
  assign pll_failed = pll_failed_q;
`else
  // Without the fallback the block retries forever and both flags are tied
  // low. MAX_RETRIES has no effect; it is referenced here only so that both
  // builds share one parameter interface.
  if (MAX_RETRIES >= 0) begin : g_no_fallback
    assign pll_bypass = 1'b0;
    assign pll_failed = 1'b0;
  end else begin : g_no_fallback_neg
    assign pll_bypass = 1'b0;
    assign pll_failed = 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pll_lock_sequencer                                        |
// | Description : Self-checking bench for pll_lock_sequencer. A time/history   |
// |               based model predicts every output each cycle; directed       |
// |               scenarios pin the model with hand-computed values, then a    |
// |               randomized lock/restart phase runs against the model.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pll_lock_sequencer;

  localparam int RC  = 4;
  localparam int LSC = 8;
  localparam int LTO = 32;
  localparam int MR  = 2;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
  localparam bit FALLBACK = 1'b1;
`else
  localparam bit FALLBACK = 1'b0;
`endif

  logic       refclk   = 1'b0;
  logic       rst_n    = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart  = 1'b0;
  logic       pll_resetb, pll_bypass, clk_ready, pll_failed;
  logic [3:0] retry_count;

  int n_checks = 0;
  int n_pass   = 0;

  pll_lock_sequencer #(
    .RESET_CYCLES      (RC),
    .LOCK_STABLE_CYCLES(LSC),
    .LOCK_TIMEOUT      (LTO),
    .MAX_RETRIES       (MR)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .restart    (restart),
    .pll_resetb (pll_resetb),
    .pll_bypass (pll_bypass),
    .clk_ready  (clk_ready),
    .pll_failed (pll_failed),
    .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  // ---------------------------------------------------------------------------
  // Reference model: tracks which phase of an attempt we are in and the edge
  // at which that phase began; lock qualification is computed from the full
  // history of sampled pll_lock values (the synchronized view at edge k is the
  // raw sample from edge k-2).
  // ---------------------------------------------------------------------------
  localparam int M_RESET = 0;
  localparam int M_WAIT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_FAIL  = 3;

  int m_n;      // index of the most recent edge since reset release (edge 0 first)
  int m_mode;
  int m_start;  // edge at which the current phase began
  int m_retry;
  bit m_hist[$];

  function automatic bit lock_s_at(int k);
    if (k < 2 || (k - 2) >= m_hist.size()) return 1'b0;
    return m_hist[k-2];
  endfunction

  task automatic model_attempt_failed();
    m_retry = (m_retry >= 15) ? 15 : m_retry + 1;
    if (FALLBACK && m_retry == MR) begin
      m_mode = M_FAIL;
    end else begin
      m_mode  = M_RESET;
      m_start = m_n;
    end
  endtask

  always @(posedge refclk or negedge rst_n) begin : model
    int run;
    if (!rst_n) begin
      m_n     = -1;
      m_mode  = M_RESET;
      m_start = -1;
      m_retry = 0;
      m_hist.delete();
    end else begin
      m_n++;
      if (restart) begin
        m_mode  = M_RESET;
        m_start = m_n;
        m_retry = 0;
      end else begin
        case (m_mode)
          M_RESET: if (m_n - m_start >= RC) begin
            m_mode  = M_WAIT;
            m_start = m_n;
          end
          M_WAIT: begin
            run = 0;
            for (int k = m_n; k > m_start; k--) begin
              if (!lock_s_at(k)) break;
              run++;
            end
            if (run >= LSC) m_mode = M_RUN;
            else if (m_n - m_start >= LTO) model_attempt_failed();
          end
          M_RUN: if (!lock_s_at(m_n)) model_attempt_failed();
          default: ;
        endcase
      end
      m_hist.push_back(pll_lock);
    end
  end

  function automatic logic [7:0] model_outputs();
    logic rb, byp, rdy, fl;
    rb  = (m_mode != M_RESET);
    byp = (m_mode == M_FAIL);
    rdy = (m_mode == M_RUN) || (m_mode == M_FAIL);
    fl  = (m_mode == M_FAIL);
    return {rb, byp, rdy, fl, 4'(m_retry)};
  endfunction

  // Every-cycle compare, away from the active edge.
  always @(negedge refclk) begin : compare
    logic [7:0] act, expv;
    if (rst_n) begin
      act  = {pll_resetb, pll_bypass, clk_ready, pll_failed, retry_count};
      expv = model_outputs();
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL model_compare edge=%0d actual={rb,byp,rdy,fail,retry}=%b required=%b",
                    m_n, act, expv);
    end
  end

  task automatic chk(string name, logic [7:0] act, logic [7:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s edge=%0d actual=%0h required=%0h", name, m_n, act, expv);
  endtask

  task automatic to_edge(int t);
    int guard;
    guard = 0;
    while (m_n < t) begin
      @(posedge refclk);
      #1;
      guard++;
      if (guard > 20000) begin
        n_checks++;
        $display("FAIL to_edge_timeout edge=%0d required=%0d", m_n, t);
        return;
      end
    end
  endtask

  function automatic logic [7:0] outs();
    return {pll_resetb, pll_bypass, clk_ready, pll_failed, retry_count};
  endfunction

  initial begin : stim
    int hold;
    // Reset state.
    repeat (3) @(posedge refclk);
    #1;
    chk("reset_state", outs(), 8'h00);
    #2 rst_n = 1'b1;

    // Clean power-up: lock first sampled at edge 10.
    to_edge(2);  chk("resetb_low_edge2", pll_resetb, 1'b0);
    to_edge(3);  chk("resetb_high_edge3", pll_resetb, 1'b1);
                 chk("ready_low_edge3", clk_ready, 1'b0);
    to_edge(9);  pll_lock = 1'b1;
    to_edge(18); chk("ready_low_edge18", clk_ready, 1'b0);
    to_edge(19); chk("ready_high_edge19", clk_ready, 1'b1);
                 chk("retry0_powerup", retry_count, 4'd0);

    // Loss in RUN: lock first sampled low at edge 26.
    to_edge(25); pll_lock = 1'b0;
    to_edge(27); chk("loss_ready_still_high", clk_ready, 1'b1);
    to_edge(28); chk("loss_ready_low", clk_ready, 1'b0);
                 chk("loss_resetb_low", pll_resetb, 1'b0);
                 chk("loss_retry1", retry_count, 4'd1);
                 pll_lock = 1'b1;
    to_edge(31); chk("relock_resetb_low", pll_resetb, 1'b0);
    to_edge(32); chk("relock_resetb_high", pll_resetb, 1'b1);
    to_edge(39); chk("relock_ready_low", clk_ready, 1'b0);
    to_edge(40); chk("relock_ready_high", clk_ready, 1'b1);

    // Lock glitch after a restart at edge 45.
    to_edge(44); restart = 1'b1; pll_lock = 1'b0;
    to_edge(45); restart = 1'b0;
                 chk("restart_clears", outs(), 8'h00);
    to_edge(50); pll_lock = 1'b1;
    to_edge(55); pll_lock = 1'b0;
    to_edge(56); pll_lock = 1'b1;
    to_edge(60); chk("glitch_restarts_count", clk_ready, 1'b0);
    to_edge(65); chk("glitch_ready_low", clk_ready, 1'b0);
    to_edge(66); chk("glitch_ready_high", clk_ready, 1'b1);

    // Restart on the same edge synchronized lock is seen low.
    to_edge(70); pll_lock = 1'b0;
    to_edge(72); chk("prio_ready_before", clk_ready, 1'b1);
                 restart = 1'b1;
    to_edge(73); restart = 1'b0;
                 chk("prio_retry0", retry_count, 4'd0);
                 chk("prio_in_reset", {pll_resetb, clk_ready}, 2'b00);
    to_edge(76); chk("prio_resetb_low", pll_resetb, 1'b0);
    to_edge(77); chk("prio_resetb_high", pll_resetb, 1'b1);

    // Timeouts with lock held low.
    to_edge(108); chk("timeout_retry0", retry_count, 4'd0);
    to_edge(109); chk("timeout1_retry1", retry_count, 4'd1);
                  chk("timeout1_resetb_low", pll_resetb, 1'b0);
    to_edge(145); chk("timeout2_retry2", retry_count, 4'd2);
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    chk("fail_flags", {pll_resetb, pll_bypass, clk_ready, pll_failed}, 4'b1111);
    to_edge(245); chk("fail_terminal", outs(), {4'b1111, 4'd2});
    restart = 1'b1;
    to_edge(246); restart = 1'b0;
                  chk("fail_restart_clears", outs(), 8'h00);
    to_edge(252);
`else
    chk("nofb_flags", {pll_resetb, pll_bypass, clk_ready, pll_failed}, 4'b0000);
    to_edge(612); chk("nofb_retry14", retry_count, 4'd14);
    to_edge(613); chk("nofb_retry15", retry_count, 4'd15);
    to_edge(649); chk("nofb_retry_sat", retry_count, 4'd15);
                  chk("nofb_bypass0", pll_bypass, 1'b0);
    to_edge(655);
`endif

    // Asynchronous reset between edges while in WAIT_LOCK.
    chk("pre_async_resetb_high", pll_resetb, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_immediate", outs(), 8'h00);
    repeat (2) @(posedge refclk);
    #1;
    chk("async_reset_held", outs(), 8'h00);
    #2 rst_n = 1'b1;

    // Randomized lock behaviour with occasional restarts.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge refclk);
      #1;
      if (hold == 0) begin
        pll_lock = ($urandom_range(0, 3) != 0);
        hold     = $urandom_range(1, 40);
      end else begin
        hold--;
      end
      restart = ($urandom_range(0, 249) == 0);
    end
    restart = 1'b0;
    @(posedge refclk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
